// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU request controller slice.
//   - SIZE_* : access size encodings on req_size
//   - lsu_state_e : controller FSM states
//   - size_mask() : byte-lane mask of an access of the given size at offset 0
//   - is_misaligned() : natural-alignment test on the low address bits
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } lsu_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    unique case (size)
      SIZE_B:  m = 8'h01;
      SIZE_H:  m = 8'h03;
      SIZE_W:  m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic mis;
    unique case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = off[0];
      SIZE_W:  mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extraction: shifts the addressed bytes of a 64-bit memory word
// down to bit 0, keeps 8/16/32/64 bits by size and sign- or zero-extends.
// Ports:
//   rdata [63:0] in  : raw memory word (8-byte aligned)
//   off   [2:0]  in  : byte offset of the access within the word
//   size  [1:0]  in  : access size (SIZE_B/H/W/D)
//   uns          in  : zero-extend instead of sign-extend (ignored for SIZE_D)
//   data  [63:0] out : extended load result
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [63:0] data
);

  logic [63:0] sh;

  always_comb begin
    sh   = rdata >> {off, 3'b000};
    data = sh;
    unique case (size)
      SIZE_B:  data = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      SIZE_H:  data = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      SIZE_W:  data = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/lsu_req_ctrl.sv
// LSU request controller: initiator side of the pmem access interface.
// Accepts one load/store at a time, optionally waits WAIT_CYCLES, issues a
// single-cycle registered read or write strobe to the memory wrapper, then
// holds the (extended) response until the consumer takes it.
// Ports:
//   clock, reset_n                : clock, async active-low reset
//   req_valid/req_ready           : request handshake
//   req_addr/wen/size/unsigned/wdata : request fields
//   resp_valid/resp_ready         : response handshake
//   resp_rdata, resp_misalign     : response payload
//   mem_raddr/waddr/wdata/wmask   : memory wrapper address/data/mask
//   mem_read_en/mem_write_en      : one-cycle access strobes
//   mem_rdata                     : memory read data, valid in strobe cycle
module lsu_req_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_W      = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_misalign,
  output logic [63:0]       mem_raddr,
  output logic [63:0]       mem_waddr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wmask,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic [63:0]       mem_rdata
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  lsu_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;
  logic              req_mis;

  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [63:0]       wdata_q;

  logic [ADDR_W-1:0] cur_addr;
  logic              cur_wen;
  logic [1:0]        cur_size;
  logic [63:0]       cur_wdata;
  logic [63:0]       line_addr;
  logic              strobe_d;
  logic [63:0]       ext_data;

  assign req_mis = is_misaligned(req_addr[2:0], req_size);

  // The strobe registers are loaded on the edge that enters ACCESS. With
  // WAIT_CYCLES == 0 that edge is the accept edge, so the fields come straight
  // from the request port; otherwise they come from the captured copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_addr  = req_addr;
      cur_wen   = req_wen;
      cur_size  = req_size;
      cur_wdata = req_wdata;
    end else begin
      cur_addr  = addr_q;
      cur_wen   = wen_q;
      cur_size  = size_q;
      cur_wdata = wdata_q;
    end
  end

  assign line_addr = 64'({cur_addr[ADDR_W-1:3], 3'b000});
  assign strobe_d  = (state_d == ST_ACCESS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (req_mis) begin
            state_d = ST_RESP;
          end else if (WAIT_CYCLES == 0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   if (resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wen_q   <= req_wen;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_ready    <= 1'b1;
      mem_raddr    <= '0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
    end else begin
      req_ready    <= (state_d == ST_IDLE);
      mem_read_en  <= strobe_d && !cur_wen;
      mem_write_en <= strobe_d && cur_wen;
      mem_raddr    <= strobe_d ? line_addr : '0;
      mem_waddr    <= strobe_d ? line_addr : '0;
      mem_wmask    <= (strobe_d && cur_wen) ? (size_mask(cur_size) << cur_addr[2:0]) : '0;
      mem_wdata    <= (strobe_d && cur_wen) ? (cur_wdata << {cur_addr[2:0], 3'b000}) : '0;
    end
  end

  lsu_load_ext u_load_ext (
    .rdata (mem_rdata),
    .off   (addr_q[2:0]),
    .size  (size_q),
    .uns   (uns_q),
    .data  (ext_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
    end else if (state_q == ST_ACCESS) begin
      resp_valid    <= 1'b1;
      resp_rdata    <= wen_q ? '0 : ext_data;
      resp_misalign <= 1'b0;
    end else if (accept && req_mis) begin
      resp_valid    <= 1'b1;
      resp_rdata    <= '0;
      resp_misalign <= 1'b1;
    end else if (state_q == ST_RESP && resp_ready) begin
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// Testbench for lsu_req_ctrl. Two instances (WAIT_CYCLES 0 and 3) share the
// request stream; a request is issued only when both are ready. Expected
// strobes and responses are derived from a byte-level reference memory and
// pushed into per-instance queues; a negedge monitor pops and compares.
module tb_lsu_req_ctrl;

  localparam int unsigned W0 = 0;
  localparam int unsigned W1 = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [63:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        resp_ready = 1'b1;

  logic        req_ready [2];
  logic        resp_valid [2];
  logic        resp_misalign [2];
  logic        mem_read_en [2];
  logic        mem_write_en [2];
  logic [63:0] resp_rdata [2];
  logic [63:0] mem_raddr [2];
  logic [63:0] mem_waddr [2];
  logic [63:0] mem_wdata [2];
  logic [63:0] mem_rdata [2];
  logic [7:0]  mem_wmask [2];

  always #5 clock = ~clock;

  lsu_req_ctrl #(.WAIT_CYCLES(W0), .ADDR_W(64)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready[0]), .req_addr(req_addr),
    .req_wen(req_wen), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata[0]), .resp_misalign(resp_misalign[0]),
    .mem_raddr(mem_raddr[0]), .mem_waddr(mem_waddr[0]), .mem_wdata(mem_wdata[0]),
    .mem_wmask(mem_wmask[0]), .mem_read_en(mem_read_en[0]),
    .mem_write_en(mem_write_en[0]), .mem_rdata(mem_rdata[0])
  );

  lsu_req_ctrl #(.WAIT_CYCLES(W1), .ADDR_W(64)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready[1]), .req_addr(req_addr),
    .req_wen(req_wen), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata[1]), .resp_misalign(resp_misalign[1]),
    .mem_raddr(mem_raddr[1]), .mem_waddr(mem_waddr[1]), .mem_wdata(mem_wdata[1]),
    .mem_wmask(mem_wmask[1]), .mem_read_en(mem_read_en[1]),
    .mem_write_en(mem_write_en[1]), .mem_rdata(mem_rdata[1])
  );

  typedef struct {
    longint unsigned cyc;
    logic [63:0]     addr;
    logic            wen;
    logic [7:0]      mask;
    logic [63:0]     wdata;
  } strobe_t;

  typedef struct {
    longint unsigned cyc;
    logic [63:0]     rdata;
    logic            mis;
  } resp_t;

  strobe_t sq [2][$];
  resp_t   rq [2][$];

  int unsigned     n_chk = 0;
  int unsigned     n_fail = 0;
  longint unsigned cyc = 0;
  int unsigned     rr_mode = 0;

  logic [63:0] wmem [2][32];
  logic [7:0]  refm [256];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] init_word(input int unsigned i);
    if (i == 0) return 64'h1122_3344_8055_6677;
    return (64'(i) * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0F0F_8080_F0F0_7F7F;
  endfunction

  function automatic longint unsigned wc(input int d);
    return (d == 0) ? longint'(W0) : longint'(W1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string act, input string req);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual %s required %s", name, act, req);
  endtask

  // Memory wrapper model: combinational read, masked write at the strobe edge.
  assign mem_rdata[0] = wmem[0][mem_raddr[0][7:3]];
  assign mem_rdata[1] = wmem[1][mem_raddr[1][7:3]];

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) wmem[d][i] = init_word(i);
    forever begin
      @(posedge clock);
      for (int d = 0; d < 2; d++)
        if (mem_write_en[d])
          for (int b = 0; b < 8; b++)
            if (mem_wmask[d][b])
              wmem[d][mem_waddr[d][7:3]][8*b +: 8] = mem_wdata[d][8*b +: 8];
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rr_mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = ($urandom_range(0, 3) != 0);
        default: resp_ready = 1'b0;
      endcase
    end
  end

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] s, input logic u);
    int unsigned nb;
    logic [63:0] v;
    nb = 1 << s;
    v  = '0;
    for (int unsigned i = 0; i < nb; i++) v |= 64'(refm[8'(a[7:0] + i)]) << (8 * i);
    if (s != 2'd3 && !u && v[8*nb-1]) v |= ~((64'd1 << (8 * nb)) - 64'd1);
    return v;
  endfunction

  // Caller must be positioned 1ns after a rising edge.
  task automatic issue(input logic [63:0] a, input logic w, input logic [1:0] s,
                       input logic u, input logic [63:0] wd);
    int unsigned     n, nb, off;
    logic            mis;
    logic [7:0]      m;
    logic [63:0]     exp_rd;
    longint unsigned acc;
    strobe_t         se;
    resp_t           re;
    n = 0;
    while (!(req_ready[0] && req_ready[1])) begin
      @(posedge clock);
      #1;
      n++;
      if (n > 200) begin
        flag("issue_timeout", "req_ready low", "req_ready high within 200 cycles");
        return;
      end
    end
    nb  = 1 << s;
    off = int'(a[2:0]);
    mis = (off % nb) != 0;
    m   = '0;
    for (int unsigned i = 0; i < nb; i++) if (off + i < 8) m[off + i] = 1'b1;
    exp_rd = (w || mis) ? 64'd0 : ref_load(a, s, u);
    req_valid = 1'b1; req_addr = a; req_wen = w; req_size = s;
    req_unsigned = u; req_wdata = wd;
    @(posedge clock);
    #1;
    acc = cyc;
    req_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (!mis) begin
        se.cyc = acc + wc(d); se.addr = {a[63:3], 3'b000}; se.wen = w;
        se.mask = m; se.wdata = wd << (8 * off);
        sq[d].push_back(se);
      end
      re.cyc = mis ? acc : acc + wc(d) + 1;
      re.rdata = exp_rd;
      re.mis = mis;
      rq[d].push_back(re);
    end
    if (!mis && w)
      for (int unsigned i = 0; i < nb; i++) refm[8'(a[7:0] + i)] = wd[8*i +: 8];
  endtask

  task automatic check_quiet(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_req_ready[%0d]", tag, d), 64'(req_ready[d]), 64'd1);
      chk($sformatf("%s_resp_valid[%0d]", tag, d), 64'(resp_valid[d]), 64'd0);
      chk($sformatf("%s_resp_rdata[%0d]", tag, d), resp_rdata[d], 64'd0);
      chk($sformatf("%s_resp_misalign[%0d]", tag, d), 64'(resp_misalign[d]), 64'd0);
      chk($sformatf("%s_read_en[%0d]", tag, d), 64'(mem_read_en[d]), 64'd0);
      chk($sformatf("%s_write_en[%0d]", tag, d), 64'(mem_write_en[d]), 64'd0);
      chk($sformatf("%s_raddr[%0d]", tag, d), mem_raddr[d], 64'd0);
      chk($sformatf("%s_waddr[%0d]", tag, d), mem_waddr[d], 64'd0);
      chk($sformatf("%s_wdata[%0d]", tag, d), mem_wdata[d], 64'd0);
      chk($sformatf("%s_wmask[%0d]", tag, d), 64'(mem_wmask[d]), 64'd0);
    end
  endtask

  // Monitor
  logic        held [2] = '{1'b0, 1'b0};
  logic [63:0] h_rd [2];
  logic        h_mis [2];

  always @(negedge clock) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        held[d] = 1'b0;
        sq[d].delete();
        rq[d].delete();
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        strobe_t se;
        resp_t   re;
        if (mem_read_en[d] && mem_write_en[d])
          flag($sformatf("strobe_both[%0d]", d), "read and write", "one strobe");
        if (mem_read_en[d] || mem_write_en[d]) begin
          if (sq[d].size() == 0) begin
            flag($sformatf("strobe_extra[%0d]", d), "strobe", "no strobe");
          end else begin
            se = sq[d].pop_front();
            chk($sformatf("strobe_cycle[%0d]", d), 64'(cyc), 64'(se.cyc));
            chk($sformatf("strobe_raddr[%0d]", d), mem_raddr[d], se.addr);
            chk($sformatf("strobe_waddr[%0d]", d), mem_waddr[d], se.addr);
            chk($sformatf("strobe_kind[%0d]", d), {62'd0, mem_write_en[d], mem_read_en[d]},
                se.wen ? 64'd2 : 64'd1);
            if (se.wen) begin
              chk($sformatf("strobe_wmask[%0d]", d), 64'(mem_wmask[d]), 64'(se.mask));
              chk($sformatf("strobe_wdata[%0d]", d), mem_wdata[d], se.wdata);
            end
          end
        end
        if (resp_valid[d]) begin
          chk($sformatf("req_ready_in_resp[%0d]", d), 64'(req_ready[d]), 64'd0);
          if (held[d]) begin
            chk($sformatf("hold_rdata[%0d]", d), resp_rdata[d], h_rd[d]);
            chk($sformatf("hold_misalign[%0d]", d), 64'(resp_misalign[d]), 64'(h_mis[d]));
          end else if (rq[d].size() == 0) begin
            flag($sformatf("resp_extra[%0d]", d), "resp_valid", "no response");
          end else begin
            re = rq[d].pop_front();
            chk($sformatf("resp_cycle[%0d]", d), 64'(cyc), 64'(re.cyc));
            chk($sformatf("resp_rdata[%0d]", d), resp_rdata[d], re.rdata);
            chk($sformatf("resp_misalign[%0d]", d), 64'(resp_misalign[d]), 64'(re.mis));
          end
          held[d]  = !resp_ready;
          h_rd[d]  = resp_rdata[d];
          h_mis[d] = resp_misalign[d];
        end else begin
          if (held[d]) flag($sformatf("resp_dropped[%0d]", d), "resp_valid low", "resp_valid held");
          held[d] = 1'b0;
        end
        if (sq[d].size() != 0 && sq[d][0].cyc < cyc) begin
          flag($sformatf("strobe_missing[%0d]", d), "no strobe", "strobe");
          void'(sq[d].pop_front());
        end
        if (rq[d].size() != 0 && rq[d][0].cyc < cyc) begin
          flag($sformatf("resp_missing[%0d]", d), "no resp_valid", "resp_valid");
          void'(rq[d].pop_front());
        end
      end
    end
  end

  initial begin
    int unsigned n;
    logic [63:0] w;
    for (int i = 0; i < 256; i++) begin
      w = init_word(i / 8);
      refm[i] = w[8*(i%8) +: 8];
    end

    #1 reset_n = 1'b0;
    #1 check_quiet("reset");
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;

    issue(64'h8000_0003, 1'b0, 2'd0, 1'b0, 64'd0);
    issue(64'h8000_0006, 1'b1, 2'd1, 1'b0, 64'h0000_0000_0000_ABCD);
    issue(64'h8000_0002, 1'b0, 2'd2, 1'b0, 64'd0);

    rr_mode = 2;
    issue(64'h8000_0000, 1'b0, 2'd3, 1'b0, 64'd0);
    n = 0;
    while (!resp_valid[1] && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("backpressure_resp_valid", 64'(resp_valid[1]), 64'd1);
    repeat (5) @(posedge clock);
    #1;
    rr_mode = 0;

    issue(64'h8000_0008, 1'b0, 2'd3, 1'b1, 64'd0);

    issue(64'h8000_0010, 1'b0, 2'd2, 1'b0, 64'd0);
    #2 reset_n = 1'b0;
    #1 check_quiet("abort");
    @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    chk("post_abort_req_ready0", 64'(req_ready[0]), 64'd1);
    chk("post_abort_req_ready1", 64'(req_ready[1]), 64'd1);

    rr_mode = 1;
    repeat (300) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(posedge clock);
        #1;
      end
      issue(64'h8000_0000 + 64'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
    end

    rr_mode = 0;
    n = 0;
    while ((rq[0].size() != 0 || rq[1].size() != 0 || resp_valid[0] || resp_valid[1]) && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain_resp_q0", 64'(rq[0].size()), 64'd0);
    chk("drain_resp_q1", 64'(rq[1].size()), 64'd0);
    chk("drain_strobe_q0", 64'(sq[0].size()), 64'd0);
    chk("drain_strobe_q1", 64'(sq[1].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_req_ctrl.md
Name: lsu_req_ctrl

Overview:
- Initiator side of the pmem access interface. Sits between the EXU and the DPI-backed memory wrapper.
- Accepts one load/store request at a time over a valid/ready handshake.
- Drives the wrapper's Raddr/Waddr/Wdata/Wmask/Read_en/Write_en as a single-cycle registered strobe, aligned to 8 bytes.
- Extracts and sign/zero-extends load data, then returns a response over a second valid/ready handshake.

Parameters:
- WAIT_CYCLES, 0: idle cycles inserted between request accept and the memory strobe, to emulate memory latency; legal range 0..15.
- ADDR_W, 64: address width.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  EXU request valid.
- req_ready  output  1  LSU can accept a request.
- req_addr  input  ADDR_W  byte address.
- req_wen  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  input  1  zero-extend load result.
- req_wdata  input  64  store data, right-aligned.
- resp_valid  output  1  response valid.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  64  extended load data; 0 for stores.
- resp_misalign  output  1  request was misaligned; no memory access was made.
- mem_raddr  output  64  to memory Raddr.
- mem_waddr  output  64  to memory Waddr.
- mem_wdata  output  64  to memory Wdata.
- mem_wmask  output  8  to memory Wmask.
- mem_read_en  output  1  to memory Read_en.
- mem_write_en  output  1  to memory Write_en.
- mem_rdata  input  64  from memory Rdata; combinational within the strobe cycle.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - All mem_* outputs = 0.
  - resp_valid = 0, resp_rdata = 0, resp_misalign = 0.
  - Wait counter = 0.
  - req_ready = 1 out of reset.
- All outputs are driven from flops; no combinational path from req_* to mem_*.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: req_ready = 1. On req_valid & req_ready, capture the request.
    - Misaligned (addr[size-1:0] != 0 for the size) -> RESP with resp_misalign = 1, resp_rdata = 0. No strobe is issued.
    - Else if WAIT_CYCLES == 0 -> ACCESS.
    - Else -> WAIT with counter = WAIT_CYCLES-1.
  - WAIT: counter decrements each cycle; at 0 -> ACCESS.
  - ACCESS: exactly one cycle.
    - mem_read_en = !wen, mem_write_en = wen.
    - mem_raddr = mem_waddr = {addr[63:3], 3'b0}.
    - For a load, capture mem_rdata at the end of this cycle.
    - Next state: RESP.
  - RESP: resp_valid = 1 and holds, with stable data, until resp_ready. On the handshake -> IDLE.
    - req_ready is 0 in WAIT, ACCESS and RESP; there is no bypass from RESP to accept.
- Strobe rule: mem_read_en and mem_write_en are never both 1, and each is high for exactly one cycle per accepted aligned request. They are 0 in every other state.
- Store formatting, with off = addr[2:0]:
  - mem_wmask = ((1 << (1 << size)) - 1) << off, truncated to 8 bits.
  - mem_wdata = req_wdata << (off*8).
- Load extraction:
  - sh = mem_rdata >> (off*8).
  - Keep the low 8/16/32/64 bits per size.
  - Sign-extend from the top kept bit unless req_unsigned. Size 3 ignores req_unsigned.
- A store response has resp_rdata = 0.
- Latency from accept to resp_valid, aligned requests: WAIT_CYCLES + 2 cycles. Misaligned: 1 cycle.
- resp_ready held high while not in RESP has no effect.
- Reset asserted in any state aborts immediately. A strobe in flight is dropped: outputs go to 0 asynchronously.

Decomposition:
- Shared package lsu_pkg holds:
  - SIZE_B/H/W/D constants.
  - State enum.
  - Function for size-to-byte-mask.
- One sub-module, lsu_load_ext: combinational shift, select and extend (inputs rdata, off, size, unsigned).

Test Plan:
- Load byte, signed: addr 0x8000_0003, mem_rdata 0x1122_3344_8055_6677, WAIT_CYCLES=0 -> one strobe with mem_raddr 0x8000_0000; resp_rdata 0xFFFF_FFFF_FFFF_FF80 two cycles after accept.
- Store half: addr 0x8000_0006, wdata 0xABCD -> mem_write_en high 1 cycle, mem_wmask 0xC0, mem_wdata 0xABCD_0000_0000_0000, resp_rdata 0.
- Misaligned word load at addr 0x8000_0002 -> no mem_read_en; resp_misalign 1 one cycle after accept.
- Backpressure: resp_ready low for 5 cycles -> resp_valid and resp_rdata stable, req_ready 0, no extra strobes.
- WAIT_CYCLES=3, load double unsigned at 0x8000_0008 -> strobe on cycle 4 after accept; resp_valid on cycle 5; data equals mem_rdata.
- Reset pulse during WAIT -> all outputs 0 immediately; after release, req_ready = 1 and no strobe from the aborted request.
